apb_slave_regfile: RTL and testbench

Parametrised APB3 slave register file for the I2C block's host interface. It generalises the earlier single-word APB slave with configurable data and address width, separate read-write and read-only register banks, programmable wait states, and PSLVERR error signalling. Control registers drive the I2C master/slave core. Status registers are read back from that core.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_reg_bank.sv | 74 +++++++
 rtl/apb_slave_regfile.sv | 144 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB register file: FSM encoding, default
// geometry and small width helpers used by the top and the register bank.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } apb_state_e;

  localparam int unsigned APB_DATA_W_DEF = 8;
  localparam int unsigned APB_ADDR_W_DEF = 8;
  localparam int unsigned APB_NUM_RW_DEF = 4;
  localparam int unsigned APB_NUM_RO_DEF = 2;

  // Total number of addressable registers (RW bank followed by RO bank).
  function automatic int unsigned num_regs(input int unsigned rw, input int unsigned ro);
    return rw + ro;
  endfunction

  // Wait counter width: enough to hold WAIT_STATES, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned ws);
    return (ws == 0) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB register file: RW control registers with
// write strobes, plus the read mux over the RW and RO (status) registers.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int unsigned       DATA_W    = APB_DATA_W_DEF,
  parameter int unsigned       ADDR_W    = APB_ADDR_W_DEF,
  parameter int unsigned       NUM_RW    = APB_NUM_RW_DEF,
  parameter int unsigned       NUM_RO    = APB_NUM_RO_DEF,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        widx_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [ADDR_W-1:0]        ridx_i,
  input  logic [NUM_RO*DATA_W-1:0] status_i,
  output logic [NUM_RW*DATA_W-1:0] ctrl_o,
  output logic [NUM_RW-1:0]        wr_strb_o,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] regs_q [NUM_RW];
  logic [DATA_W-1:0] regs_d [NUM_RW];
  logic [NUM_RW-1:0] strb_q;
  logic [NUM_RW-1:0] strb_d;
  logic [31:0]       widx;
  logic [31:0]       ridx;

  assign widx = 32'(widx_i);
  assign ridx = 32'(ridx_i);

  // Write decode: only an in-range RW index updates storage and raises its strobe.
  always_comb begin
    strb_d = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      regs_d[k] = regs_q[k];
      if (we_i && (widx == 32'(k))) begin
        regs_d[k] = wdata_i;
        strb_d[k] = 1'b1;
      end
    end
  end

  // Register storage and single-cycle strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_RW; k++) regs_q[k] <= RESET_VAL;
      strb_q <= '0;
    end else begin
      for (int k = 0; k < NUM_RW; k++) regs_q[k] <= regs_d[k];
      strb_q <= strb_d;
    end
  end

  // Read mux: RW registers first, then status; anything else reads as zero.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (ridx == 32'(k)) rdata_o = regs_q[k];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (ridx == 32'(NUM_RW + k)) rdata_o = status_i[k*DATA_W +: DATA_W];
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_strb_o = strb_q;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 slave register file for the I2C host interface: FSM, wait-state
// counter and error decode; storage lives in apb_reg_bank.
//
// Handshake: a transfer starts with a SETUP cycle (PSEL_i=1, PENABLE_i=0)
// and continues with ACCESS cycles (PSEL_i=PENABLE_i=1) while PADDR_i,
// PWRITE_i and PWDATA_i are held stable. It completes in the ACCESS cycle
// where PREADY_o=1; PRDATA_o and PSLVERR_o are valid only in that cycle.
// Dropping PSEL_i before completion abandons the transfer with no side effects.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned       DATA_W      = APB_DATA_W_DEF,
  parameter int unsigned       ADDR_W      = APB_ADDR_W_DEF,
  parameter int unsigned       NUM_RW      = APB_NUM_RW_DEF,
  parameter int unsigned       NUM_RO      = APB_NUM_RO_DEF,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                     PCLK_i,
  input  logic                     PRESET_N_i,
  input  logic                     PSEL_i,
  input  logic                     PENABLE_i,
  input  logic                     PWRITE_i,
  input  logic [ADDR_W-1:0]        PADDR_i,
  input  logic [DATA_W-1:0]        PWDATA_i,
  output logic [DATA_W-1:0]        PRDATA_o,
  output logic                     PREADY_o,
  output logic                     PSLVERR_o,
  output logic [NUM_RW*DATA_W-1:0] ctrl_o,
  output logic [NUM_RW-1:0]        wr_strb_o,
  input  logic [NUM_RO*DATA_W-1:0] status_i,
  output apb_state_e               state_o
);

  localparam int unsigned      NUM_REGS = num_regs(NUM_RW, NUM_RO);
  localparam int unsigned      CNT_W    = cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  apb_state_e        state_q, state_d, cur_state;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              enter_done;
  logic              bank_we;
  logic [DATA_W-1:0] bank_rdata;
  logic [31:0]       idx;
  logic              is_rw, is_ro, addr_err;

  // Index decode: invalid index, or a write aimed at a status register, is an error.
  assign idx      = 32'(PADDR_i);
  assign is_rw    = (idx < NUM_RW);
  assign is_ro    = !is_rw && (idx < NUM_REGS);
  assign addr_err = !(is_rw || is_ro) || (PWRITE_i && is_ro);

  // Next state and response. SETUP is the APB setup cycle itself, recognised
  // from IDLE combinationally so the first ACCESS cycle can already be DONE.
  always_comb begin
    cur_state = state_q;
    if ((state_q == ST_IDLE) && PSEL_i && !PENABLE_i) cur_state = ST_SETUP;
    state_d    = cur_state;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    bank_we    = 1'b0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    case (cur_state)
      ST_IDLE: state_d = ST_IDLE;
      ST_SETUP: begin
        if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (!PSEL_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        bank_we = PSEL_i && PENABLE_i && PWRITE_i && pready_q && !pslverr_q;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_done) begin
      pready_d  = 1'b1;
      pslverr_d = addr_err;
      prdata_d  = (addr_err || PWRITE_i) ? '0 : bank_rdata;
    end
  end

  // FSM, wait counter and registered APB response.
  always_ff @(posedge PCLK_i or negedge PRESET_N_i) begin
    if (!PRESET_N_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_reg_bank #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RW   (NUM_RW),
    .NUM_RO   (NUM_RO),
    .RESET_VAL(RESET_VAL)
  ) u_bank (
    .clk_i    (PCLK_i),
    .rst_ni   (PRESET_N_i),
    .we_i     (bank_we),
    .widx_i   (PADDR_i),
    .wdata_i  (PWDATA_i),
    .ridx_i   (PADDR_i),
    .status_i (status_i),
    .ctrl_o   (ctrl_o),
    .wr_strb_o(wr_strb_o),
    .rdata_o  (bank_rdata)
  );

  assign PRDATA_o  = prdata_q;
  assign PREADY_o  = pready_q;
  assign PSLVERR_o = pslverr_q;
  assign state_o   = cur_state;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 3 wait states, reset
// value A5), driver tasks feeding a reference model and an expected queue,
// and a monitor that checks each completed transfer and the strobes after it.
`timescale 1ns/1ps
module tb_apb_slave_regfile;
  import apb_pkg::*;

  localparam int         NDUT  = 2;
  localparam logic [7:0] RST_V = 8'hA5;

  typedef struct packed {
    logic        dut;
    logic [3:0]  lat;
    logic        err;
    logic [7:0]  rdata;
    logic [3:0]  strb;
    logic [31:0] ctrl;
  } exp_t;

  logic        clk, rst_n;
  logic        psel [NDUT], penable [NDUT], pwrite [NDUT];
  logic [7:0]  paddr [NDUT], pwdata [NDUT], prdata [NDUT];
  logic        pready [NDUT], pslverr [NDUT];
  logic [31:0] ctrl [NDUT];
  logic [3:0]  strb [NDUT];
  logic [15:0] status [NDUT];
  apb_state_e  st [NDUT];

  exp_t        exp_q[$];
  logic [7:0]  ref_ctrl [NDUT][4];
  int          checks = 0;
  int          errors = 0;
  bit          pend [NDUT];
  exp_t        pend_e [NDUT];
  int          cyc [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_slave_regfile #(
      .DATA_W(8), .ADDR_W(8), .NUM_RW(4), .NUM_RO(2),
      .WAIT_STATES((g == 0) ? 0 : 3), .RESET_VAL(RST_V)
    ) u_dut (
      .PCLK_i    (clk),
      .PRESET_N_i(rst_n),
      .PSEL_i    (psel[g]),
      .PENABLE_i (penable[g]),
      .PWRITE_i  (pwrite[g]),
      .PADDR_i   (paddr[g]),
      .PWDATA_i  (pwdata[g]),
      .PRDATA_o  (prdata[g]),
      .PREADY_o  (pready[g]),
      .PSLVERR_o (pslverr[g]),
      .ctrl_o    (ctrl[g]),
      .wr_strb_o (strb[g]),
      .status_i  (status[g]),
      .state_o   (st[g])
    );
  end

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_flat(input int d);
    return {ref_ctrl[d][3], ref_ctrl[d][2], ref_ctrl[d][1], ref_ctrl[d][0]};
  endfunction

  task automatic ref_reset();
    for (int d = 0; d < NDUT; d++)
      for (int k = 0; k < 4; k++) ref_ctrl[d][k] = RST_V;
  endtask

  task automatic apb_idle(input int n);
    for (int d = 0; d < NDUT; d++) begin
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full transfer; the expected response comes from the register map rules.
  task automatic apb_xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] data);
    exp_t        e;
    logic [15:0] s;
    int          n;
    e       = '0;
    e.dut   = d[0];
    e.lat   = (d == 0) ? 4'd2 : 4'd5;
    if (addr < 8'd4) begin
      if (wr) begin
        ref_ctrl[d][addr[1:0]] = data;
        e.strb = 4'b0001 << addr[1:0];
      end else begin
        e.rdata = ref_ctrl[d][addr[1:0]];
      end
    end else if (addr < 8'd6) begin
      if (wr) e.err = 1'b1;
      else begin
        s       = status[d];
        e.rdata = addr[0] ? s[15:8] : s[7:0];
      end
    end else begin
      e.err = 1'b1;
    end
    e.ctrl = ref_flat(d);
    exp_q.push_back(e);

    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = data;
    @(posedge clk);
    #1;
    penable[d] = 1'b1;
    n = 0;
    while (!pready[d] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout: dut %0d got no PREADY in 40 cycles, required completion", d);
    end
    @(posedge clk);
    #1;
  endtask

  // Write started and then abandoned by dropping PSEL after ncyc ACCESS cycles.
  task automatic apb_abort(input int d, input logic [7:0] addr, input logic [7:0] data, input int ncyc);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b1;
    paddr[d]   = addr;
    pwdata[d]  = data;
    @(posedge clk);
    #1;
    penable[d] = 1'b1;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
    end
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk({tag, "_ctrl"},    ctrl[d], {4{RST_V}});
      chk({tag, "_pready"},  32'(pready[d]), 32'd0);
      chk({tag, "_pslverr"}, 32'(pslverr[d]), 32'd0);
      chk({tag, "_prdata"},  32'(prdata[d]), 32'd0);
      chk({tag, "_strb"},    32'(strb[d]), 32'd0);
      chk({tag, "_state"},   32'(st[d]), 32'(ST_IDLE));
    end
  endtask

  task automatic rand_bursts(input int nb);
    for (int i = 0; i < nb; i++) begin
      int         d;
      int         len;
      bit         wr;
      logic [7:0] a;
      d   = $urandom_range(0, 1);
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) begin
        wr = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
        apb_xfer(d, wr, a, 8'($urandom));
      end
      apb_idle(1);
      if ($urandom_range(0, 2) == 0) status[$urandom_range(0, 1)] = 16'($urandom);
      apb_idle($urandom_range(0, 1));
    end
  endtask

  // Monitor: pops one expectation per completed transfer, then checks the
  // strobe and control outputs in the cycle after completion.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < NDUT; d++) pend[d] = 1'b0;
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        if (pend[d]) begin
          chk("wr_strb", 32'(strb[d]), 32'(pend_e[d].strb));
          chk("ctrl", ctrl[d], pend_e[d].ctrl);
          pend[d] = 1'b0;
        end else begin
          chk("wr_strb_idle", 32'(strb[d]), 32'd0);
        end
        if (psel[d] && !penable[d]) cyc[d] = 1;
        else if (psel[d]) cyc[d]++;
        if (pready[d]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pready: dut %0d got PREADY=1, required no response", d);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_dut", 32'(d), 32'(e.dut));
            chk("latency", 32'(cyc[d]), 32'(e.lat));
            chk("pslverr", 32'(pslverr[d]), 32'(e.err));
            chk("prdata", 32'(prdata[d]), 32'(e.rdata));
            pend[d]   = 1'b1;
            pend_e[d] = e;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0;  pwdata[d] = '0;    status[d] = 16'h0000;
      cyc[d] = 0;
    end
    ref_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    #2 rst_n = 1'b1;
    apb_idle(2);

    // Zero-wait instance: write/read, errors, back-to-back writes
    apb_xfer(0, 1'b1, 8'd2, 8'h3C); apb_idle(1);
    apb_xfer(0, 1'b0, 8'd2, 8'h00); apb_idle(1);
    apb_xfer(0, 1'b0, 8'd9, 8'h00); apb_idle(1);
    apb_xfer(0, 1'b1, 8'd5, 8'hFF); apb_idle(1);
    apb_xfer(0, 1'b1, 8'd0, 8'h11);
    apb_xfer(0, 1'b1, 8'd1, 8'h22);
    apb_xfer(0, 1'b1, 8'd1, 8'h33);
    apb_idle(2);

    // Three-wait instance: status reads, write then read back
    status[1] = 16'h7E81;
    apb_idle(1);
    apb_xfer(1, 1'b0, 8'd4, 8'h00); apb_idle(1);
    apb_xfer(1, 1'b0, 8'd5, 8'h00); apb_idle(1);
    apb_xfer(1, 1'b1, 8'd3, 8'h5A);
    apb_xfer(1, 1'b0, 8'd3, 8'h00);
    apb_xfer(1, 1'b0, 8'd200, 8'h00); apb_idle(1);

    // Abort after one wait cycle: no response, no write, FSM idle
    apb_abort(1, 8'd0, 8'h99, 1);
    @(posedge clk);
    #1;
    chk("abort_state", 32'(st[1]), 32'(ST_IDLE));
    chk("abort_ctrl", ctrl[1], ref_flat(1));
    chk("abort_pready", 32'(pready[1]), 32'd0);
    apb_idle(3);

    rand_bursts(25);

    // Asynchronous reset in the middle of a pending write on the wait-state instance
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'd2; pwdata[1] = 8'hC3;
    @(posedge clk);
    #1;
    penable[1] = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    ref_reset();
    apb_idle(1);
    rst_n = 1'b1;
    apb_idle(2);
    chk("post_reset_ctrl", ctrl[1], ref_flat(1));

    rand_bursts(15);

    apb_idle(4);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
